caliptra_prim_fifo_sync_wm: RTL and testbench
=============================================

Name: caliptra_prim_fifo_sync_wm

Overview:
Generic synchronous FIFO: the next generation of the team's sync FIFO primitive. It adds programmable almost-full and almost-empty thresholds, a high-watermark occupancy tracker, and a sticky overflow flag for software-visible status. Intended for mailbox, SHA/AES data staging and DMA paths where firmware monitors FIFO pressure. Supports pass-through on empty and non-power-of-two depths.

Parameters:
Width, 32, data width in bits (>=1)
Depth, 8, number of storage entries (>=2; non-power-of-two allowed)
Pass, 1, when 1 a write into an empty FIFO is visible on the read port in the same cycle
OutputZeroIfEmpty, 1, when 1 rdata_o is driven to 0 whenever rvalid_o is 0
DepthW, derived, vbits(Depth+1); width of all occupancy and threshold signals

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
clr_i  input  1  synchronous flush
wvalid_i  input  1  write request
wready_o  output  1  write accept
wdata_i  input  Width  write data
rvalid_o  output  1  read data valid
rready_i  input  1  read accept
rdata_o  output  Width  read data
full_o  output  1  occupancy == Depth
depth_o  output  DepthW  current occupancy
af_th_i  input  DepthW  almost-full threshold
ae_th_i  input  DepthW  almost-empty threshold
almost_full_o  output  1  depth_o >= af_th_i
almost_empty_o  output  1  depth_o <= ae_th_i
wm_o  output  DepthW  maximum occupancy since the last clear
wm_clr_i  input  1  reload watermark with current occupancy
ovf_o  output  1  sticky: write attempted while full
ovf_clr_i  input  1  clear ovf_o

Behaviour:
- Reset: one clock, asynchronous active-high reset. On reset, depth_o=0, pointers=0, wm_o=0, ovf_o=0, full_o=0, and the under_rst flag is set. Storage is not reset.
- under_rst: set by reset and cleared on the first clock edge after release. While it is set, wready_o=0 and rvalid_o=0, so no push or pop can occur.
- wready_o = !full_o & !under_rst.
- rvalid_o = !empty & !under_rst.
  - empty = (depth==0) & !(Pass & wvalid_i).
- push = wvalid_i & wready_o.
- pop = rvalid_o & rready_i.
- Pass-through case (Pass=1, depth==0, push & pop in the same cycle): rdata_o=wdata_i, storage is not written, pointers and depth are unchanged.
- In all other cases:
  - A push writes storage[wptr].
  - rdata_o = storage[rptr].
  - depth_next = depth + push - pop.
- Pointers advance by 1 per push or pop and wrap from Depth-1 to 0, with no power-of-two assumption.
- Full behaviour: when full_o=1, wready_o stays 0 even if a pop occurs in the same cycle, so there is no write-through on full.
- Read latency: 0 cycles from storage; registered data sits on rdata_o while rvalid_o=1 and rready_i=0.
- rdata_o is stable while rvalid_o=1 and rready_i=0.
- OutputZeroIfEmpty=1: rdata_o=0 whenever empty.
- Status outputs:
  - almost_full_o and almost_empty_o are combinational from the registered depth_o and the live thresholds.
  - af_th_i=0 forces almost_full_o=1.
  - ae_th_i>=Depth forces almost_empty_o=1.
- Watermark:
  - Each cycle, wm <= max(wm, depth_next).
  - wm_clr_i: wm <= depth_next.
  - clr_i: wm <= 0. clr_i has priority over wm_clr_i.
- Overflow:
  - Set on (wvalid_i & full_o & !under_rst).
  - ovf_clr_i clears it; if a set condition and ovf_clr_i occur in the same cycle, set wins.
  - clr_i does not clear ovf_o.
- clr_i:
  - Next cycle: depth=0, pointers=0, wm=0.
  - A push or pop in the same cycle is discarded (clr wins).
  - Outputs in the clr cycle itself are unaffected.
- Invariants (asserted):
  - depth_o <= Depth.
  - rdata_o is known whenever rvalid_o=1.
  - depth_o, rvalid_o and wready_o are never X after reset.

Test Plan:
- Reset then idle: release rst_i -> wready_o=0 for 1 cycle then 1; depth_o=0, rvalid_o=0, rdata_o=0, wm_o=0, ovf_o=0.
- Fill and drain, Depth=8: push 0x11..0x88 with rready_i=0 -> full_o=1 after the 8th push, wm_o=8; a 9th write sets ovf_o=1 and data is dropped; draining returns 0x11..0x88 in order, then depth_o=0.
- Pass-through: empty, wvalid_i=1 with wdata_i=0xCAFE and rready_i=1 in the same cycle -> rvalid_o=1, rdata_o=0xCAFE in the same cycle, depth_o stays 0.
- Thresholds: af_th_i=6, ae_th_i=2; push 6 -> almost_full_o rises when depth_o=6 and almost_empty_o drops at depth 3; pop to 2 -> almost_empty_o=1.
- Wrap and simultaneous push/pop, Depth=5: random traffic for 100 items with scoreboard -> in-order data across pointer wrap; depth unchanged on simultaneous push and pop.
- Clear/watermark priority: depth=4, wm_o=6; assert clr_i with a push and wm_clr_i in the same cycle -> next cycle depth_o=0, wm_o=0, push dropped, ovf_o unchanged; then wm_clr_i at depth 3 -> wm_o=3.

Source files
------------

// File: rtl/caliptra_prim_fifo_sync_wm.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// a high-watermark occupancy tracker and a sticky overflow flag.
// Depth need not be a power of two; the pointers wrap explicitly at Depth-1.

module caliptra_prim_fifo_sync_wm #(
    parameter int unsigned Width             = 32,
    parameter int unsigned Depth             = 8,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic              full_o,
    output logic [DepthW-1:0] depth_o,
    input  logic [DepthW-1:0] af_th_i,
    input  logic [DepthW-1:0] ae_th_i,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [DepthW-1:0] wm_o,
    input  logic              wm_clr_i,
    output logic              ovf_o,
    input  logic              ovf_clr_i
);

    localparam int unsigned        PtrW      = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0]    PtrMax    = PtrW'(Depth - 1);
    localparam logic [DepthW-1:0]  DepthFull = DepthW'(Depth);

    // Advance a pointer by one, wrapping from Depth-1 back to zero.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == PtrMax) begin
            nxt = {PtrW{1'b0}};
        end else begin
            nxt = ptr + PtrW'(1'b1);
        end
        return nxt;
    endfunction

    logic [Width-1:0]  storage_r [Depth];
    logic [PtrW-1:0]   wptr_r;
    logic [PtrW-1:0]   rptr_r;
    logic [DepthW-1:0] depth_r;
    logic [DepthW-1:0] wm_r;
    logic              ovf_r;
    logic              under_rst_r;

    logic              depth_zero_s;
    logic              full_s;
    logic              empty_s;
    logic              wready_s;
    logic              rvalid_s;
    logic              push_s;
    logic              pop_s;
    logic              pass_s;
    logic              write_en_s;
    logic [PtrW-1:0]   wptr_next_s;
    logic [PtrW-1:0]   rptr_next_s;
    logic [DepthW-1:0] depth_next_s;
    logic [DepthW-1:0] wm_next_s;
    logic              ovf_next_s;
    logic [Width-1:0]  rdata_s;

    // Handshake qualification: nothing moves while the reset flag is up.
    always_comb begin
        depth_zero_s = (depth_r == {DepthW{1'b0}});
        full_s       = (depth_r == DepthFull);
        empty_s      = depth_zero_s & ~(Pass & wvalid_i);
        wready_s     = ~full_s & ~under_rst_r;
        rvalid_s     = ~empty_s & ~under_rst_r;
        push_s       = wvalid_i & wready_s;
        pop_s        = rvalid_s & rready_i;
        pass_s       = Pass & depth_zero_s & push_s & pop_s;
        write_en_s   = push_s & ~pass_s & ~clr_i;
    end

    // Next occupancy and pointers; a flush discards any same-cycle push/pop.
    always_comb begin
        depth_next_s = depth_r;
        wptr_next_s  = wptr_r;
        rptr_next_s  = rptr_r;
        if (clr_i) begin
            depth_next_s = {DepthW{1'b0}};
            wptr_next_s  = {PtrW{1'b0}};
            rptr_next_s  = {PtrW{1'b0}};
        end else if (pass_s) begin
            depth_next_s = depth_r;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    depth_next_s = depth_r + DepthW'(1'b1);
                    wptr_next_s  = ptr_inc(wptr_r);
                end
                2'b01: begin
                    depth_next_s = depth_r - DepthW'(1'b1);
                    rptr_next_s  = ptr_inc(rptr_r);
                end
                2'b11: begin
                    wptr_next_s  = ptr_inc(wptr_r);
                    rptr_next_s  = ptr_inc(rptr_r);
                end
                default: begin
                    depth_next_s = depth_r;
                end
            endcase
        end
    end

    // Watermark and overflow next state; flush beats watermark reload, set beats clear.
    always_comb begin
        wm_next_s  = wm_r;
        ovf_next_s = ovf_r;
        if (clr_i) begin
            wm_next_s = {DepthW{1'b0}};
        end else if (wm_clr_i) begin
            wm_next_s = depth_next_s;
        end else if (depth_next_s > wm_r) begin
            wm_next_s = depth_next_s;
        end else begin
            wm_next_s = wm_r;
        end
        if (wvalid_i & full_s & ~under_rst_r) begin
            ovf_next_s = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Control state registers; clr_i acts as the synchronous flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_r      <= {PtrW{1'b0}};
            rptr_r      <= {PtrW{1'b0}};
            depth_r     <= {DepthW{1'b0}};
            wm_r        <= {DepthW{1'b0}};
            ovf_r       <= 1'b0;
            under_rst_r <= 1'b1;
        end else begin
            wptr_r      <= wptr_next_s;
            rptr_r      <= rptr_next_s;
            depth_r     <= depth_next_s;
            wm_r        <= wm_next_s;
            ovf_r       <= ovf_next_s;
            under_rst_r <= 1'b0;
        end
    end

    // Data storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (write_en_s) begin
            storage_r[wptr_r] <= wdata_i;
        end
    end

    // Read data: bypass on empty, else head of storage, zeroed when not valid.
    always_comb begin
        rdata_s = storage_r[rptr_r];
        if (OutputZeroIfEmpty && !rvalid_s) begin
            rdata_s = {Width{1'b0}};
        end else if (Pass && depth_zero_s && wvalid_i) begin
            rdata_s = wdata_i;
        end else begin
            rdata_s = storage_r[rptr_r];
        end
    end

    // Output mapping; status flags derive from registered occupancy.
    always_comb begin
        wready_o       = wready_s;
        rvalid_o       = rvalid_s;
        rdata_o        = rdata_s;
        full_o         = full_s;
        depth_o        = depth_r;
        wm_o           = wm_r;
        ovf_o          = ovf_r;
        almost_full_o  = (depth_r >= af_th_i);
        almost_empty_o = (depth_r <= ae_th_i) || (ae_th_i >= DepthFull);
    end

    caliptra_prim_fifo_sync_wm_chk #(
        .Width  (Width),
        .DepthW (DepthW),
        .Depth  (Depth)
    ) u_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .depth_o  (depth_r),
        .rvalid_o (rvalid_s),
        .wready_o (wready_s),
        .rdata_o  (rdata_s)
    );

endmodule

// Invariant checker for the FIFO; holds only properties, no logic.
module caliptra_prim_fifo_sync_wm_chk #(
    parameter int unsigned Width  = 32,
    parameter int unsigned DepthW = 4,
    parameter int unsigned Depth  = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    input logic [DepthW-1:0] depth_o,
    input logic              rvalid_o,
    input logic              wready_o,
    input logic [Width-1:0]  rdata_o
);

    a_depth_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        depth_o <= DepthW'(Depth));

    a_rdata_known: assert property (@(posedge clk_i) disable iff (rst_i)
        rvalid_o |-> !$isunknown(rdata_o));

    a_ctrl_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown({depth_o, rvalid_o, wready_o}));

endmodule

// File: tb/tb_caliptra_prim_fifo_sync_wm.sv
// Directed bench for the watermark FIFO: a Depth=8 instance for the directed
// scenarios and a Depth=5 instance for wrap-around traffic against a queue.

module tb_caliptra_prim_fifo_sync_wm;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    // Depth = 8 instance signals
    logic        clr, wvalid, rready, wm_clr, ovf_clr;
    logic [31:0] wdata;
    logic [3:0]  af_th, ae_th;
    logic        wready, rvalid, full, almost_full, almost_empty, ovf;
    logic [31:0] rdata;
    logic [3:0]  depth, wm;

    // Depth = 5 instance signals
    logic        wvalid5, rready5;
    logic [31:0] wdata5;
    logic        wready5, rvalid5, full5, af5, ae5, ovf5;
    logic [31:0] rdata5;
    logic [2:0]  depth5, wm5;

    always #5 clk = ~clk;

    caliptra_prim_fifo_sync_wm #(.Width(32), .Depth(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
        .full_o(full), .depth_o(depth), .af_th_i(af_th), .ae_th_i(ae_th),
        .almost_full_o(almost_full), .almost_empty_o(almost_empty),
        .wm_o(wm), .wm_clr_i(wm_clr), .ovf_o(ovf), .ovf_clr_i(ovf_clr)
    );

    caliptra_prim_fifo_sync_wm #(.Width(32), .Depth(5)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .clr_i(1'b0),
        .wvalid_i(wvalid5), .wready_o(wready5), .wdata_i(wdata5),
        .rvalid_o(rvalid5), .rready_i(rready5), .rdata_o(rdata5),
        .full_o(full5), .depth_o(depth5), .af_th_i(3'd4), .ae_th_i(3'd1),
        .almost_full_o(af5), .almost_empty_o(ae5),
        .wm_o(wm5), .wm_clr_i(1'b0), .ovf_o(ovf5), .ovf_clr_i(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q5[$];
    logic [31:0] exp_rd;
    logic        exp_wr, exp_rv, push5, pop5;
    int          sent, recv;

    initial begin
        rst = 1'b1; clr = 1'b0; wvalid = 1'b0; rready = 1'b0; wm_clr = 1'b0;
        ovf_clr = 1'b0; wdata = 32'd0; af_th = 4'd6; ae_th = 4'd2;
        wvalid5 = 1'b0; rready5 = 1'b0; wdata5 = 32'd0;

        // Reset, then one cycle of under_rst
        #12 rst = 1'b0;
        #1;
        chk("wready_under_rst", wready, 1'b0);
        chk("rvalid_under_rst", rvalid, 1'b0);
        tick();
        chk("wready_idle", wready, 1'b1);
        chk("depth_idle", depth, 4'd0);
        chk("rvalid_idle", rvalid, 1'b0);
        chk("rdata_idle", rdata, 32'd0);
        chk("wm_idle", wm, 4'd0);
        chk("ovf_idle", ovf, 1'b0);
        chk("full_idle", full, 1'b0);

        // Fill with 0x11..0x88
        for (int i = 1; i <= 8; i++) begin
            wvalid = 1'b1;
            wdata  = 32'h11 * i;
            tick();
        end
        wvalid = 1'b0;
        #1;
        chk("full_after_8", full, 1'b1);
        chk("depth_after_8", depth, 4'd8);
        chk("wm_after_8", wm, 4'd8);
        chk("wready_full", wready, 1'b0);
        chk("rdata_head", rdata, 32'h11);

        // Ninth write with ovf_clr in the same cycle: set wins, data dropped
        wvalid = 1'b1; wdata = 32'h99; ovf_clr = 1'b1;
        #1;
        chk("wready_9th", wready, 1'b0);
        tick();
        wvalid = 1'b0; ovf_clr = 1'b0;
        #1;
        chk("ovf_set", ovf, 1'b1);
        chk("depth_after_9th", depth, 4'd8);
        tick();
        chk("rdata_stable", rdata, 32'h11);

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            rready = 1'b1;
            #1;
            chk("drain_data", rdata, 32'h11 * i);
            tick();
        end
        rready = 1'b0;
        #1;
        chk("depth_drained", depth, 4'd0);
        chk("rvalid_drained", rvalid, 1'b0);
        chk("rdata_zero_empty", rdata, 32'd0);
        chk("full_drained", full, 1'b0);

        // Pass-through on empty
        wvalid = 1'b1; wdata = 32'hCAFE; rready = 1'b1;
        #1;
        chk("pass_rvalid", rvalid, 1'b1);
        chk("pass_rdata", rdata, 32'hCAFE);
        tick();
        wvalid = 1'b0; rready = 1'b0;
        #1;
        chk("pass_depth", depth, 4'd0);
        chk("pass_rvalid_after", rvalid, 1'b0);

        // Thresholds af=6, ae=2
        chk("af_at_0", almost_full, 1'b0);
        chk("ae_at_0", almost_empty, 1'b1);
        for (int d = 1; d <= 6; d++) begin
            wvalid = 1'b1;
            wdata  = 32'h100 + d;
            tick();
            wvalid = 1'b0;
            #1;
            chk("thr_depth", depth, d);
            chk("thr_af", almost_full, (d >= 6));
            chk("thr_ae", almost_empty, (d <= 2));
        end
        for (int k = 0; k < 4; k++) begin
            rready = 1'b1;
            tick();
        end
        rready = 1'b0;
        #1;
        chk("depth_pop_to_2", depth, 4'd2);
        chk("ae_at_2", almost_empty, 1'b1);
        chk("af_at_2", almost_full, 1'b0);
        af_th = 4'd0;
        #1;
        chk("af_forced_th0", almost_full, 1'b1);
        af_th = 4'd6;

        // Watermark reload, then build depth=4 with wm=6
        wm_clr = 1'b1;
        tick();
        wm_clr = 1'b0;
        #1;
        chk("wm_reload_2", wm, 4'd2);
        for (int k = 0; k < 4; k++) begin
            wvalid = 1'b1;
            wdata  = 32'h21 + k;
            tick();
        end
        wvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rready = 1'b1;
            tick();
        end
        rready = 1'b0;
        #1;
        chk("pre_clr_depth", depth, 4'd4);
        chk("pre_clr_wm", wm, 4'd6);

        // clr with push and wm_clr: clr wins, ovf untouched
        clr = 1'b1; wvalid = 1'b1; wdata = 32'hEE; wm_clr = 1'b1;
        #1;
        chk("clr_cycle_depth", depth, 4'd4);
        chk("clr_cycle_rvalid", rvalid, 1'b1);
        tick();
        clr = 1'b0; wvalid = 1'b0; wm_clr = 1'b0;
        #1;
        chk("post_clr_depth", depth, 4'd0);
        chk("post_clr_wm", wm, 4'd0);
        chk("post_clr_ovf", ovf, 1'b1);
        chk("post_clr_rvalid", rvalid, 1'b0);

        // Refill after clr: pointers restart cleanly
        for (int k = 0; k < 4; k++) begin
            wvalid = 1'b1;
            wdata  = 32'hA1 + k;
            tick();
        end
        wvalid = 1'b0;
        #1;
        chk("post_clr_head", rdata, 32'hA1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        #1;
        chk("depth_3", depth, 4'd3);
        chk("wm_4", wm, 4'd4);
        chk("rdata_a2", rdata, 32'hA2);
        wm_clr = 1'b1;
        tick();
        wm_clr = 1'b0;
        #1;
        chk("wm_reload_3", wm, 4'd3);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        #1;
        chk("ovf_cleared", ovf, 1'b0);

        // Depth=5 traffic across pointer wrap, queue model
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 3000 && recv < 100; cyc++) begin
            wvalid5 = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            wdata5  = $urandom;
            rready5 = 1'($urandom_range(0, 1));
            #1;
            exp_wr = (q5.size() < 5);
            exp_rv = (q5.size() > 0) || wvalid5;
            chk("d5_wready", wready5, exp_wr);
            chk("d5_rvalid", rvalid5, exp_rv);
            push5 = wvalid5 && exp_wr;
            pop5  = exp_rv && rready5;
            if (pop5) begin
                exp_rd = (q5.size() == 0) ? wdata5 : q5[0];
                chk("d5_rdata", rdata5, exp_rd);
            end
            if (!(push5 && pop5 && q5.size() == 0)) begin
                if (push5) q5.push_back(wdata5);
                if (pop5)  void'(q5.pop_front());
            end
            if (push5) sent++;
            if (pop5)  recv++;
            tick();
            chk("d5_depth", depth5, q5.size());
        end
        wvalid5 = 1'b0; rready5 = 1'b0;
        chk("d5_items_received", recv, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
